// File: rtl/frame_reader.sv
// Streams one stored frame from memory_block as a byte stream; FRAME_READER_FCS_EN appends the Ethernet FCS.
// Latency: start sampled at edge N -> first tx_valid after edge N+2; one byte/cycle thereafter.
// Backpressure: reads are credit-limited to a 4-entry buffer; tx_* holds stable while tx_ready is low.

module fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic          rd_vld,
    output logic [W-1:0]  rd_dat,
    output logic [AW:0]   count
);
    // Generic power-of-two FIFO, head exposed combinationally from storage.
    // Latency: a write is visible at the head the cycle after it is taken.
    // Backpressure: writes into a full FIFO are dropped unless a read frees a slot that cycle.

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign do_rd  = rd_vld && rd_rdy;
    assign do_wr  = wr_vld && ((count != (AW+1)'(DEPTH)) || do_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

module frame_reader #(
    parameter int SIZE  = 1024,
    parameter int WIDTH = $clog2(SIZE),
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base_addr,
    input  logic [LEN_W-1:0] length,
    output logic [WIDTH-1:0] addr_r,
    input  logic [7:0]       data_r,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic             busy,
    output logic             done
);
    localparam int CAP = 4;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FCS} state_t;

    state_t           state;
    logic [LEN_W-1:0] rem;        // reads still to issue
    logic [LEN_W:0]   send_rem;   // bytes still to hand over, FCS included
    logic [LEN_W:0]   total;
    logic             p1;         // addr_r holds a read the memory samples next edge
    logic             p2;         // data_r carries a byte to capture next edge
    logic [2:0]       cnt;
    logic [3:0]       in_use;
    logic             credit;
    logic             pop;
    logic             final_hs;
    logic             accept;
    logic             push;
    logic [7:0]       push_dat;

    assign pop      = tx_valid && tx_ready;
    assign final_hs = pop && (send_rem == (LEN_W+1)'(1));
    assign tx_last  = tx_valid && (send_rem == (LEN_W+1)'(1));
    assign in_use   = {1'b0, cnt} + {3'b0, p1} + {3'b0, p2};
    assign credit   = in_use < 4'(CAP);
    assign accept   = (state == IDLE) && start && (length != '0);

`ifdef FRAME_READER_FCS_EN
    logic [31:0] crc;
    logic [31:0] fcs_val;
    logic [2:0]  fcs_cnt;
    logic        fcs_push;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    assign fcs_val  = ~crc;
    assign fcs_push = (state == FCS) && (fcs_cnt != 3'd4) && (cnt != 3'(CAP));
    assign push     = p2 || fcs_push;
    assign push_dat = p2 ? data_r : fcs_val[{fcs_cnt[1:0], 3'b000} +: 8];
    assign total    = (LEN_W+1)'(length) + (LEN_W+1)'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc     <= '1;
            fcs_cnt <= '0;
        end else if (accept) begin
            crc     <= '1;
            fcs_cnt <= '0;
        end else begin
            if (p2)       crc     <= crc_step(crc, data_r);
            if (fcs_push) fcs_cnt <= fcs_cnt + 3'd1;
        end
    end
`else
    assign push     = p2;
    assign push_dat = data_r;
    assign total    = (LEN_W+1)'(length);
`endif

    fifo #(.DEPTH(CAP), .W(8)) u_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push),
        .wr_dat (push_dat),
        .rd_rdy (tx_ready),
        .rd_vld (tx_valid),
        .rd_dat (tx_data),
        .count  (cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_r   <= '0;
            rem      <= '0;
            send_rem <= '0;
            p1       <= 1'b0;
            p2       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            p2   <= p1;
            p1   <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    addr_r   <= base_addr;
                    rem      <= length - LEN_W'(1);
                    send_rem <= total;
                    p1       <= 1'b1;
                    busy     <= 1'b1;
                    state    <= FETCH;
                end
                FETCH: begin
                    if (rem == '0) begin
                        state <= DRAIN;
                    end else if (credit) begin
                        addr_r <= addr_r + WIDTH'(1);
                        rem    <= rem - LEN_W'(1);
                        p1     <= 1'b1;
                    end
                end
`ifdef FRAME_READER_FCS_EN
                // Hand over to FCS as the last data byte is captured so no bubble appears.
                DRAIN: if (!p1) state <= FCS;
`endif
                default: ;
            endcase
            if (pop) send_rem <= send_rem - (LEN_W+1)'(1);
            if (final_hs) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_frame_reader.sv
// Scoreboard bench for frame_reader with a registered-read memory model; honours FRAME_READER_FCS_EN.
`timescale 1ns/1ps
module tb_frame_reader;
    localparam int SIZE  = 1024;
    localparam int WIDTH = 10;
    localparam int LEN_W = 11;
`ifdef FRAME_READER_FCS_EN
    localparam bit FCS = 1'b1;
`else
    localparam bit FCS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] base_addr = '0;
    logic [LEN_W-1:0] length = '0;
    logic [WIDTH-1:0] addr_r;
    logic [7:0]       data_r;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b1;
    logic             tx_last;
    logic             busy;
    logic             done;

    logic [7:0] mem [SIZE];
    logic [8:0] exp_q [$];
    logic [8:0] mon_e;
    int         n_chk = 0;
    int         n_fail = 0;
    int         hs_cnt = 0;
    int         done_cnt = 0;
    logic       rand_rdy = 1'b0;
    logic       stalled = 1'b0;
    logic [7:0] held_dat;
    logic       held_last;

    frame_reader #(.SIZE(SIZE), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .addr_r    (addr_r),
        .data_r    (data_r),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_last   (tx_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) data_r <= mem[addr_r];

    always @(posedge clk) begin
        #1;
        tx_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (stalled) begin
                check("hold_data", tx_data, held_dat);
                check("hold_valid", tx_valid, 1);
                check("hold_last", tx_last, held_last);
            end
            stalled   = tx_valid && !tx_ready;
            held_dat  = tx_data;
            held_last = tx_last;
            if (tx_valid && tx_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("spurious_byte", tx_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tx_data", tx_data, mon_e[7:0]);
                    check("tx_last", tx_last, mon_e[8]);
                end
            end
        end
    end

    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = (r >> 1) ^ (fb ? 32'hEDB8_8320 : 32'h0);
        end
        return r;
    endfunction

    task automatic push_frame(input int b, input int l);
        logic [31:0] c;
        logic [7:0]  by;
        logic        lst;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < l; i++) begin
            by  = mem[(b + i) % SIZE];
            c   = crc_model(c, by);
            lst = !FCS && (i == l - 1);
            exp_q.push_back({lst, by});
        end
        c = ~c;
        for (int k = 0; k < 4; k++)
            if (FCS) exp_q.push_back({k == 3, c[8*k +: 8]});
    endtask

    task automatic drive_start(input logic [WIDTH-1:0] b, input logic [LEN_W-1:0] l);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic end_frame(input string tag, input int d0);
        for (int c = 0; c < 4000 && done_cnt == d0; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_once"}, done_cnt, d0 + 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, tx_valid, 0);
        check({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int         d0;
        int         h0;
        logic [9:0] alog [$];
        logic [9:0] prev;

        for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
        mem[16'h010] = 8'hAA; mem[16'h011] = 8'hBB;
        mem[16'h012] = 8'hCC; mem[16'h013] = 8'hDD;

        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", addr_r, 0);
        check("rst_data", tx_data, 0);
        check("rst_valid", tx_valid, 0);
        check("rst_last", tx_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // basic frame, latency and back-to-back output
        d0 = done_cnt;
        push_frame(16'h010, 4);
        drive_start(10'h010, 11'd4);
        check("t1_busy", busy, 1);
        check("t1_valid_n", tx_valid, 0);
        @(posedge clk); #1;
        check("t1_valid_n1", tx_valid, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check("t1_valid_run", tx_valid, 1);
            check("t1_last_run", tx_last, !FCS && (i == 3));
            @(posedge clk); #1;
        end
        end_frame("t1", d0);

        // address wrap at the top of the buffer
        d0 = done_cnt;
        push_frame(10'h3FE, 4);
        drive_start(10'h3FE, 11'd4);
        prev = addr_r;
        alog.push_back(addr_r);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (addr_r != prev) alog.push_back(addr_r);
            prev = addr_r;
        end
        check("t2_addr_cnt", alog.size(), 4);
        while (alog.size() < 4) alog.push_back(10'h2AA);
        check("t2_addr0", alog[0], 10'h3FE);
        check("t2_addr1", alog[1], 10'h3FF);
        check("t2_addr2", alog[2], 10'h000);
        check("t2_addr3", alog[3], 10'h001);
        end_frame("t2", d0);

        // long frame under random backpressure
        d0 = done_cnt;
        rand_rdy = 1'b1;
        push_frame(16'h040, 64);
        drive_start(10'h040, 11'd64);
        end_frame("t3", d0);
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);

        // zero-length start and start while busy are ignored
        d0 = done_cnt;
        drive_start(10'h100, 11'd0);
        repeat (10) @(posedge clk);
        #1;
        check("t4_zero_busy", busy, 0);
        check("t4_zero_done", done_cnt, d0);
        check("t4_zero_valid", tx_valid, 0);
        push_frame(16'h120, 12);
        drive_start(10'h120, 11'd12);
        start = 1'b1; base_addr = 10'h200; length = 11'd5;
        @(posedge clk); #1;
        start = 1'b0;
        end_frame("t4", d0);

        // reset in the middle of a frame
        d0 = done_cnt;
        h0 = hs_cnt;
        push_frame(16'h180, 64);
        drive_start(10'h180, 11'd64);
        for (int c = 0; c < 500 && hs_cnt < h0 + 10; c++) @(negedge clk);
        check("t5_reached10", hs_cnt >= h0 + 10, 1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t5_addr", addr_r, 0);
        check("t5_data", tx_data, 0);
        check("t5_valid", tx_valid, 0);
        check("t5_last", tx_last, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t5_idle_valid", tx_valid, 0);
        check("t5_idle_done", done_cnt, d0);
        d0 = done_cnt;
        push_frame(16'h300, 16);
        drive_start(10'h300, 11'd16);
        end_frame("t5_new", d0);

`ifdef FRAME_READER_FCS_EN
        // known CRC-32 check value over "123456789"
        for (int i = 0; i < 9; i++) mem[16'h080 + i] = 8'(8'h31 + i);
        d0 = done_cnt;
        for (int i = 0; i < 9; i++) exp_q.push_back({1'b0, 8'(8'h31 + i)});
        exp_q.push_back(9'h026);
        exp_q.push_back(9'h039);
        exp_q.push_back(9'h0F4);
        exp_q.push_back(9'h1CB);
        drive_start(10'h080, 11'd9);
        end_frame("t6", d0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
